add_sub_norm_pipe: RTL and testbench

- Normalization stage of the FPU add/sub datapath; sits directly upstream of the exponent-adjust stage and feeds it.
- Takes the raw mantissa sum from the significand adder, finds the leading-one position, and classifies the result as carry-out (overflow), exponent-exhausting (underflow) or zero.
- Outputs the normalized mantissa plus the LOPD count and flags that the exponent-adjust stage consumes.
- Two-stage valid/ready pipeline; sign and exponent ride alongside.

---
 rtl/fpu_add_sub_pkg.sv | 12 +
 rtl/add_sub_lopd.sv | 21 ++
 rtl/add_sub_norm_pipe.sv | 162 ++++++++++++++++
 tb/tb_add_sub_norm_pipe.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fpu_add_sub_pkg.sv
// Shared constants and flag bundle for the FPU add/sub datapath stages.
package fpu_add_sub_pkg;
  localparam int SIZE_MANT = 24;
  localparam int SIZE_EXP  = 8;
  localparam int SIZE_LOPD = 8;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic zero;
  } norm_flags_t;
endpackage

// File: rtl/add_sub_lopd.sv
// Leading-one priority encoder: count of zeros above the first set bit, plus an all-zero flag.
module add_sub_lopd #(
  parameter int SIZE_MANT = 24,
  parameter int SIZE_LOPD = 8
) (
  input  logic [SIZE_MANT-1:0] i_mant,
  output logic [SIZE_LOPD-1:0] o_lopd,
  output logic                 o_all_zero
);

  always_comb begin
    o_lopd = '0;
    // Higher bits are visited last so the most significant one wins.
    for (int i = 0; i < SIZE_MANT; i++) begin
      if (i_mant[i]) o_lopd = SIZE_LOPD'(SIZE_MANT - 1 - i);
    end
  end

  assign o_all_zero = ~|i_mant;

endmodule

// File: rtl/add_sub_norm_pipe.sv
// Two-stage normalization of the significand sum: classify and count in stage 1,
// shift into the normalized mantissa in stage 2.
module add_sub_norm_pipe #(
  parameter int SIZE_MANT = fpu_add_sub_pkg::SIZE_MANT,
  parameter int SIZE_EXP  = fpu_add_sub_pkg::SIZE_EXP,
  parameter int SIZE_LOPD = fpu_add_sub_pkg::SIZE_LOPD
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_sign,
  input  logic [SIZE_EXP-1:0]  i_exp_value,
  input  logic [SIZE_MANT:0]   i_mant_sum,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_sign,
  output logic [SIZE_EXP-1:0]  o_exp_value,
  output logic                 o_overflow,
  output logic                 o_underflow,
  output logic                 o_zero_flag,
  output logic [SIZE_LOPD-1:0] o_lopd_value,
  output logic [SIZE_MANT-1:0] o_mant_norm,
  output logic                 o_sticky
);
  import fpu_add_sub_pkg::norm_flags_t;

  localparam int CW = (SIZE_LOPD > SIZE_EXP) ? SIZE_LOPD : SIZE_EXP;

  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_sign_q, s1_sign_d;
  logic [SIZE_EXP-1:0]  s1_exp_q, s1_exp_d;
  logic [SIZE_MANT:0]   s1_sum_q, s1_sum_d;
  logic [SIZE_LOPD-1:0] s1_lopd_q, s1_lopd_d;
  norm_flags_t          s1_flags_q, s1_flags_d;

  logic                 s2_valid_q, s2_valid_d;
  logic                 s2_sign_q, s2_sign_d;
  logic [SIZE_EXP-1:0]  s2_exp_q, s2_exp_d;
  logic [SIZE_LOPD-1:0] s2_lopd_q, s2_lopd_d;
  norm_flags_t          s2_flags_q, s2_flags_d;
  logic [SIZE_MANT-1:0] s2_mant_q, s2_mant_d;
  logic                 s2_sticky_q, s2_sticky_d;

  logic                 s1_advance;
  logic [SIZE_LOPD-1:0] lopd_raw;
  logic                 all_zero;
  logic                 in_overflow, in_zero;
  logic [SIZE_LOPD-1:0] in_lopd;

  add_sub_lopd #(
    .SIZE_MANT (SIZE_MANT),
    .SIZE_LOPD (SIZE_LOPD)
  ) u_lopd (
    .i_mant     (i_mant_sum[SIZE_MANT-1:0]),
    .o_lopd     (lopd_raw),
    .o_all_zero (all_zero)
  );

  assign s1_advance = ~s2_valid_q | i_ready;
  assign o_ready    = ~s1_valid_q | s1_advance;

  assign in_overflow = i_mant_sum[SIZE_MANT];
  assign in_zero     = all_zero & ~in_overflow;
  assign in_lopd     = (in_overflow | in_zero) ? '0 : lopd_raw;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_exp_d   = s1_exp_q;
    s1_sum_d   = s1_sum_q;
    s1_lopd_d  = s1_lopd_q;
    s1_flags_d = s1_flags_q;
    if (o_ready) begin
      s1_valid_d = i_valid;
      if (i_valid) begin
        s1_sign_d           = i_sign;
        s1_exp_d            = i_exp_value;
        s1_sum_d            = i_mant_sum;
        s1_lopd_d           = in_lopd;
        s1_flags_d.overflow = in_overflow;
        s1_flags_d.zero     = in_zero;
        s1_flags_d.underflow = ~in_overflow & ~in_zero &
                               (CW'(in_lopd) >= CW'(i_exp_value));
      end
    end
  end

  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_sign_d   = s2_sign_q;
    s2_exp_d    = s2_exp_q;
    s2_lopd_d   = s2_lopd_q;
    s2_flags_d  = s2_flags_q;
    s2_mant_d   = s2_mant_q;
    s2_sticky_d = s2_sticky_q;
    if (s1_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_d   = s1_sign_q;
        s2_exp_d    = s1_exp_q;
        s2_lopd_d   = s1_lopd_q;
        s2_flags_d  = s1_flags_q;
        s2_sticky_d = 1'b0;
        if (s1_flags_q.zero) begin
          s2_mant_d = '0;
        end else if (s1_flags_q.overflow) begin
          s2_mant_d   = s1_sum_q[SIZE_MANT:1];
          s2_sticky_d = s1_sum_q[0];
        end else if (s1_flags_q.underflow) begin
          // Left unshifted; the exponent-adjust stage keeps the exponent as is.
          s2_mant_d = s1_sum_q[SIZE_MANT-1:0];
        end else begin
          s2_mant_d = s1_sum_q[SIZE_MANT-1:0] << s1_lopd_q;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_sum_q    <= '0;
      s1_lopd_q   <= '0;
      s1_flags_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_exp_q    <= '0;
      s2_lopd_q   <= '0;
      s2_flags_q  <= '0;
      s2_mant_q   <= '0;
      s2_sticky_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_exp_q    <= s1_exp_d;
      s1_sum_q    <= s1_sum_d;
      s1_lopd_q   <= s1_lopd_d;
      s1_flags_q  <= s1_flags_d;
      s2_valid_q  <= s2_valid_d;
      s2_sign_q   <= s2_sign_d;
      s2_exp_q    <= s2_exp_d;
      s2_lopd_q   <= s2_lopd_d;
      s2_flags_q  <= s2_flags_d;
      s2_mant_q   <= s2_mant_d;
      s2_sticky_q <= s2_sticky_d;
    end
  end

  assign o_valid      = s2_valid_q;
  assign o_sign       = s2_sign_q;
  assign o_exp_value  = s2_exp_q;
  assign o_overflow   = s2_flags_q.overflow;
  assign o_underflow  = s2_flags_q.underflow;
  assign o_zero_flag  = s2_flags_q.zero;
  assign o_lopd_value = s2_lopd_q;
  assign o_mant_norm  = s2_mant_q;
  assign o_sticky     = s2_sticky_q;

endmodule

// File: tb/tb_add_sub_norm_pipe.sv
// Directed checks of the normalization pipe: single vectors, a stalled stream and mid-stream reset.
module tb_add_sub_norm_pipe;
  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic        i_sign;
  logic [7:0]  i_exp_value;
  logic [24:0] i_mant_sum;
  logic        o_valid;
  logic        i_ready;
  logic        o_sign;
  logic [7:0]  o_exp_value;
  logic        o_overflow;
  logic        o_underflow;
  logic        o_zero_flag;
  logic [7:0]  o_lopd_value;
  logic [23:0] o_mant_norm;
  logic        o_sticky;

  int total = 0;
  int bad   = 0;

  logic [23:0] got_mant[$];
  logic [7:0]  got_exp[$];
  logic [7:0]  got_lopd[$];
  logic        got_sticky[$];

  add_sub_norm_pipe dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_sign       (i_sign),
    .i_exp_value  (i_exp_value),
    .i_mant_sum   (i_mant_sum),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_sign       (o_sign),
    .o_exp_value  (o_exp_value),
    .o_overflow   (o_overflow),
    .o_underflow  (o_underflow),
    .o_zero_flag  (o_zero_flag),
    .o_lopd_value (o_lopd_value),
    .o_mant_norm  (o_mant_norm),
    .o_sticky     (o_sticky)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!i_rst && o_valid && i_ready) begin
      got_mant.push_back(o_mant_norm);
      got_exp.push_back(o_exp_value);
      got_lopd.push_back(o_lopd_value);
      got_sticky.push_back(o_sticky);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input string tag, input logic sgn, input logic [24:0] sum,
                         input logic [7:0] expv, input logic e_ov, input logic e_un,
                         input logic e_z, input logic [7:0] e_lopd,
                         input logic [23:0] e_mant, input logic e_sticky);
    chk({tag, "_ready"}, 32'(o_ready), 32'd1);
    i_valid = 1'b1; i_sign = sgn; i_exp_value = expv; i_mant_sum = sum;
    step();
    i_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(o_valid), 32'd0);
    step();
    chk({tag, "_valid"}, 32'(o_valid), 32'd1);
    chk({tag, "_sign"}, 32'(o_sign), 32'(sgn));
    chk({tag, "_exp"}, 32'(o_exp_value), 32'(expv));
    chk({tag, "_flags"}, 32'({o_overflow, o_underflow, o_zero_flag}), 32'({e_ov, e_un, e_z}));
    chk({tag, "_lopd"}, 32'(o_lopd_value), 32'(e_lopd));
    chk({tag, "_mant"}, 32'(o_mant_norm), 32'(e_mant));
    chk({tag, "_sticky"}, 32'(o_sticky), 32'(e_sticky));
    step();
    chk({tag, "_drain"}, 32'(o_valid), 32'd0);
  endtask

  logic [23:0] exp_mant[4];
  logic [7:0]  exp_exp[4];
  logic [7:0]  exp_lopd[4];
  logic        exp_sticky[4];

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_sign = 1'b0; i_exp_value = '0; i_mant_sum = '0;
    step(); step();
    i_rst = 1'b0;
    step();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_mant", 32'(o_mant_norm), 32'd0);
    chk("rst_flags", 32'({o_overflow, o_underflow, o_zero_flag, o_sticky}), 32'd0);

    run_vec("norm", 1'b0, 25'h0800000, 8'd130, 1'b0, 1'b0, 1'b0, 8'd0,  24'h800000, 1'b0);
    run_vec("ovf",  1'b1, 25'h1000001, 8'd127, 1'b1, 1'b0, 1'b0, 8'd0,  24'h800000, 1'b1);
    run_vec("shft", 1'b0, 25'h0000100, 8'd100, 1'b0, 1'b0, 1'b0, 8'd15, 24'h800000, 1'b0);
    run_vec("unf",  1'b1, 25'h0000001, 8'd10,  1'b0, 1'b1, 1'b0, 8'd23, 24'h000001, 1'b0);
    run_vec("zero", 1'b0, 25'h0000000, 8'd50,  1'b0, 1'b0, 1'b1, 8'd0,  24'h000000, 1'b0);
    // lopd equal to exponent is still underflow
    run_vec("unfeq", 1'b0, 25'h0000100, 8'd15, 1'b0, 1'b1, 1'b0, 8'd15, 24'h000100, 1'b0);

    exp_mant[0] = 24'hC00000; exp_exp[0] = 8'd20; exp_lopd[0] = 8'd0;  exp_sticky[0] = 1'b0;
    exp_mant[1] = 24'hA00000; exp_exp[1] = 8'd40; exp_lopd[1] = 8'd13; exp_sticky[1] = 1'b0;
    exp_mant[2] = 24'h800001; exp_exp[2] = 8'd60; exp_lopd[2] = 8'd0;  exp_sticky[2] = 1'b1;
    exp_mant[3] = 24'h000010; exp_exp[3] = 8'd3;  exp_lopd[3] = 8'd19; exp_sticky[3] = 1'b0;
    got_mant.delete(); got_exp.delete(); got_lopd.delete(); got_sticky.delete();

    i_ready = 1'b1;
    i_valid = 1'b1; i_exp_value = 8'd20; i_mant_sum = 25'h0C00000;
    step();
    i_exp_value = 8'd40; i_mant_sum = 25'h0000500;
    step();
    i_ready = 1'b0;
    i_exp_value = 8'd60; i_mant_sum = 25'h1000003;
    #1;
    chk("stall_ready_drop", 32'(o_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_valid", 32'(o_valid), 32'd1);
      chk("stall_mant", 32'(o_mant_norm), 32'hC00000);
      chk("stall_exp", 32'(o_exp_value), 32'd20);
      chk("stall_ready", 32'(o_ready), 32'd0);
    end
    i_ready = 1'b1;
    step();
    i_exp_value = 8'd3; i_mant_sum = 25'h0000010;
    step();
    i_valid = 1'b0;
    for (int k = 0; k < 10 && got_mant.size() < 4; k++) step();
    chk("stream_count", 32'(got_mant.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < got_mant.size()) begin
        chk($sformatf("stream%0d_mant", k), 32'(got_mant[k]), 32'(exp_mant[k]));
        chk($sformatf("stream%0d_exp", k), 32'(got_exp[k]), 32'(exp_exp[k]));
        chk($sformatf("stream%0d_lopd", k), 32'(got_lopd[k]), 32'(exp_lopd[k]));
        chk($sformatf("stream%0d_sticky", k), 32'(got_sticky[k]), 32'(exp_sticky[k]));
      end
    end
    step(); step();
    chk("stream_empty", 32'(o_valid), 32'd0);

    i_ready = 1'b0;
    i_valid = 1'b1; i_exp_value = 8'd77; i_mant_sum = 25'h0400000;
    step();
    i_exp_value = 8'd88; i_mant_sum = 25'h0200000;
    step();
    i_valid = 1'b0;
    chk("pre_rst_valid", 32'(o_valid), 32'd1);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_ready", 32'(o_ready), 32'd1);
    chk("mid_rst_mant", 32'(o_mant_norm), 32'd0);
    step();
    chk("post_rst_valid", 32'(o_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
